spike_rate_pwm: RTL

- Downstream consumer of LIF_neuron `spike`: counts rising spike edges over a fixed window to produce a firing-rate word.
- Maps that rate to a clamped servo PWM duty for a leg joint of the robo dog.
- Sits between a neuron (or CPG neuron pair) and the joint servo pin.
- Rate-coded neuron output becomes joint position/effort.

---
 rtl/spike_rate_pwm.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spike_rate_pwm.sv
// Counts rising spike edges per fixed window into a rate word and maps it to a clamped servo PWM duty.
// Optional EMA smoothing of the rate (alpha = 1/4) is enabled with `define SPIKE_RATE_SMOOTH_EN.
module spike_rate_pwm #(
    parameter int WIN_LEN    = 1000,
    parameter int CNT_W      = 8,
    parameter int PWM_PERIOD = 2000,
    parameter int DUTY_W     = 12,
    parameter int PWM_MIN    = 100,
    parameter int PWM_GAIN   = 4,
    parameter int PWM_MAX    = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              spike,
    output logic [CNT_W-1:0]  rate,
    output logic              rate_valid,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int MAP_W = CNT_W + $clog2(PWM_GAIN) + DUTY_W + 1;
    localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WIN_LEN - 1);
    localparam logic [DUTY_W-1:0] FRAME_LAST = DUTY_W'(PWM_PERIOD - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
        if (inc && (a != {CNT_W{1'b1}})) begin
            return a + CNT_W'(1);
        end else begin
            return a;
        end
    endfunction

    function automatic logic [DUTY_W-1:0] duty_map(input logic [CNT_W-1:0] r);
        logic [MAP_W-1:0] lin;
        lin = MAP_W'(PWM_MIN) + MAP_W'(r) * MAP_W'(PWM_GAIN);
        if (lin > MAP_W'(PWM_MAX)) begin
            return DUTY_W'(PWM_MAX);
        end else begin
            return lin[DUTY_W-1:0];
        end
    endfunction

    logic                spike_q;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]    spk_cnt_q, spk_cnt_d;
    logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [DUTY_W-1:0]   duty_next_q, duty_next_d;
    logic                rate_valid_q, rate_valid_d;
    logic                pwm_q, pwm_d;
    logic                edge_s;
    logic [CNT_W-1:0]    win_sum_s;
    logic [CNT_W-1:0]    rate_now_s;
`ifdef SPIKE_RATE_SMOOTH_EN
    logic [CNT_W+1:0]        rate_filt_q, rate_filt_d;
    logic signed [CNT_W+3:0] filt_diff_s;
    logic signed [CNT_W+3:0] filt_step_s;

    assign rate_now_s = rate_filt_q[CNT_W+1:2];
`else
    logic [CNT_W-1:0]    rate_q, rate_d;

    assign rate_now_s = rate_q;
`endif

    assign rate       = rate_now_s;
    assign rate_valid = rate_valid_q;
    assign duty       = duty_q;
    assign pwm        = pwm_q;

    // Next-state logic: edge counting, window close, duty mapping and PWM frame.
    always_comb begin
        edge_s       = spike & ~spike_q;
        win_sum_s    = sat_inc(spk_cnt_q, edge_s);
        duty_next_d  = duty_map(rate_now_s);
        win_cnt_d    = '0;
        spk_cnt_d    = '0;
        pwm_cnt_d    = '0;
        duty_d       = duty_q;
        pwm_d        = 1'b0;
        rate_valid_d = 1'b0;
`ifdef SPIKE_RATE_SMOOTH_EN
        filt_diff_s  = $signed({2'b00, win_sum_s, 2'b00}) - $signed({2'b00, rate_filt_q});
        filt_step_s  = filt_diff_s >>> 2;
        rate_filt_d  = rate_filt_q;
`else
        rate_d       = rate_q;
`endif
        if (en) begin
            pwm_d = (pwm_cnt_q < duty_q);
            // Duty only changes at the frame boundary so a frame is never cut short.
            if (pwm_cnt_q == FRAME_LAST) begin
                pwm_cnt_d = '0;
                duty_d    = duty_next_q;
            end else begin
                pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);
                duty_d    = duty_q;
            end
            // An edge seen in the terminal cycle belongs to the closing window.
            if (win_cnt_q == WIN_LAST) begin
                win_cnt_d    = '0;
                spk_cnt_d    = '0;
                rate_valid_d = 1'b1;
`ifdef SPIKE_RATE_SMOOTH_EN
                rate_filt_d  = rate_filt_q + filt_step_s[CNT_W+1:0];
`else
                rate_d       = win_sum_s;
`endif
            end else begin
                win_cnt_d    = win_cnt_q + WIN_W'(1);
                spk_cnt_d    = win_sum_s;
                rate_valid_d = 1'b0;
            end
        end else begin
            win_cnt_d    = '0;
            spk_cnt_d    = '0;
            pwm_cnt_d    = '0;
            pwm_d        = 1'b0;
            rate_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            spike_q      <= 1'b0;
            win_cnt_q    <= '0;
            spk_cnt_q    <= '0;
            pwm_cnt_q    <= '0;
            duty_q       <= DUTY_W'(PWM_MIN);
            duty_next_q  <= DUTY_W'(PWM_MIN);
            rate_valid_q <= 1'b0;
            pwm_q        <= 1'b0;
`ifdef SPIKE_RATE_SMOOTH_EN
            rate_filt_q  <= '0;
`else
            rate_q       <= '0;
`endif
        end else begin
            spike_q      <= spike;
            win_cnt_q    <= win_cnt_d;
            spk_cnt_q    <= spk_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            duty_q       <= duty_d;
            duty_next_q  <= duty_next_d;
            rate_valid_q <= rate_valid_d;
            pwm_q        <= pwm_d;
`ifdef SPIKE_RATE_SMOOTH_EN
            rate_filt_q  <= rate_filt_d;
`else
            rate_q       <= rate_d;
`endif
        end
    end

endmodule
